// File: rtl/coderom_banked_if.sv
// coderom_banked_if: CPU read port and byte-serial loader bundle for coderom_banked.
interface coderom_banked_if #(
    parameter int DW     = 16,
    parameter int AW     = 13,
    parameter int NBANKS = 4
);
    localparam int BW = NBANKS > 1 ? $clog2(NBANKS) : 1;
    logic [AW-1:0]     a;
    logic [NBANKS-1:0] ce_n;
    logic [DW-1:0]     out;
    logic              valid;
    logic              ld_en;
    logic              ld_we;
    logic [7:0]        ld_byte;
    logic              ld_busy;
    logic [AW+BW-1:0]  ld_count;
    logic              ld_ovf;
    modport master (output a, ce_n, ld_en, ld_we, ld_byte,
                    input  out, valid, ld_busy, ld_count, ld_ovf);
    modport slave  (input  a, ce_n, ld_en, ld_we, ld_byte,
                    output out, valid, ld_busy, ld_count, ld_ovf);
endinterface

// File: rtl/coderom_banked.sv
// coderom_banked: N-bank code ROM with pipelined priority-selected read port and byte-serial loader.
module coderom_banked #(
    parameter int DW     = 16,
    parameter int AW     = 13,
    parameter int NBANKS = 4,
    parameter int LAT    = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    coderom_banked_if.slave bus
);
    localparam int BW    = NBANKS > 1 ? $clog2(NBANKS) : 1;
    localparam int CW    = AW + BW;
    localparam int NB    = DW / 8;
    localparam int DEPTH = NBANKS << AW;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t          r_state, w_state_nx;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [DW-1:0]   r_shift, w_word;
    logic [2:0]      r_idx, w_idx_nx;
    logic [CW-1:0]   r_count, w_cnt;
    logic            r_ovf, r_ld_en_d;
    logic            w_take, w_wr, w_rise;
    logic [AW-1:0]   r_addr;
    logic [BW-1:0]   r_sel, w_sel;
    logic            r_hit, r_v1, r_v2;
    logic [DW-1:0]   r_d1, r_d2;

    // Bytes enter at the bottom and shift up, so the first byte ends in the MSBs.
    assign w_word = DW'({r_shift, bus.ld_byte});

    always_comb begin
        w_take     = bus.ld_en & bus.ld_we;
        w_rise     = bus.ld_en & ~r_ld_en_d;
        w_cnt      = w_rise ? '0 : r_count;
        w_wr       = w_take & (NB == 1 || (r_state == ACCUM && r_idx == 3'(NB - 1)));
        w_state_nx = (!bus.ld_en || w_wr) ? IDLE : (w_take ? ACCUM : r_state);
        w_idx_nx   = (!bus.ld_en || w_wr) ? '0 : (w_take ? r_idx + 3'd1 : r_idx);
    end

    always_comb begin
        w_sel = '0;
        for (int i = NBANKS - 1; i >= 0; i--)
            if (!bus.ce_n[i]) w_sel = BW'(i);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_shift   <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_ld_en_d <= 1'b0;
        end else begin
            r_ld_en_d <= bus.ld_en;
            if (w_take) r_shift <= w_word;
            r_count   <= w_wr ? (w_cnt == LAST ? '0 : w_cnt + 1'b1) : w_cnt;
            r_ovf     <= (w_wr && w_cnt == LAST) | (r_ovf & ~w_rise);
        end

    // Bank-major word index doubles as the flat array index.
    always_ff @(posedge clk)
        if (w_wr) r_mem[w_cnt] <= w_word;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_addr <= '0;
            r_sel  <= '0;
            r_hit  <= 1'b0;
            r_d1   <= '0;
            r_v1   <= 1'b0;
            r_d2   <= '0;
            r_v2   <= 1'b0;
        end else begin
            r_addr <= bus.a;
            r_sel  <= w_sel;
            r_hit  <= ~&bus.ce_n & ~bus.ld_en;
            r_d1   <= r_hit ? r_mem[{r_sel, r_addr}] : '0;
            r_v1   <= r_hit;
            r_d2   <= r_d1;
            r_v2   <= r_v1;
        end

    assign bus.out      = LAT == 2 ? r_d2 : r_d1;
    assign bus.valid    = LAT == 2 ? r_v2 : r_v1;
    assign bus.ld_busy  = r_state == ACCUM;
    assign bus.ld_count = r_count;
    assign bus.ld_ovf   = r_ovf;
endmodule

// File: tb/tb_coderom_banked.sv
// tb_coderom_banked: directed and randomized checks of coderom_banked in three configurations.
module tb_coderom_banked;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    coderom_banked_if #(.DW(16), .AW(13), .NBANKS(4)) ifa ();
    coderom_banked_if #(.DW(16), .AW(2),  .NBANKS(3)) ifb ();
    coderom_banked_if #(.DW(8),  .AW(2),  .NBANKS(2)) ifc ();

    coderom_banked #(.DW(16), .AW(13), .NBANKS(4), .LAT(1)) ua (.clk(clk), .reset_n(reset_n), .bus(ifa));
    coderom_banked #(.DW(16), .AW(2),  .NBANKS(3), .LAT(2)) ub (.clk(clk), .reset_n(reset_n), .bus(ifb));
    coderom_banked #(.DW(8),  .AW(2),  .NBANKS(2), .LAT(1)) uc (.clk(clk), .reset_n(reset_n), .bus(ifc));

    int total = 0;
    int bad = 0;
    logic [15:0] mb [12];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic sa(input logic [7:0] b);
        ifa.ld_we = 1'b1; ifa.ld_byte = b; step();
    endtask

    task automatic sb(input logic [7:0] b);
        ifb.ld_we = 1'b1; ifb.ld_byte = b; step();
    endtask

    task automatic sc(input logic [7:0] b);
        ifc.ld_we = 1'b1; ifc.ld_byte = b; step();
    endtask

    task automatic rda(input logic [12:0] addr, input logic [3:0] ce);
        ifa.ld_en = 1'b0; ifa.ld_we = 1'b0; ifa.a = addr; ifa.ce_n = ce; step(2);
    endtask

    function automatic logic [15:0] wa(input int i);
        return 16'(i) ^ 16'h5A3C;
    endfunction

    // Lowest enabled bank wins; no enabled bank reads as invalid zero.
    function automatic logic [16:0] ref_b(input int ad, input logic [2:0] ce);
        for (int k = 0; k < 3; k++)
            if (!ce[k]) return {1'b1, mb[k * 4 + ad]};
        return 17'd0;
    endfunction

    initial begin
        logic [15:0] w;
        logic [16:0] e;
        logic [16:0] q [$];
        int ad;
        logic [2:0] ce;
        ifa.a = '0; ifa.ce_n = '1; ifa.ld_en = 0; ifa.ld_we = 0; ifa.ld_byte = 0;
        ifb.a = '0; ifb.ce_n = '1; ifb.ld_en = 0; ifb.ld_we = 0; ifb.ld_byte = 0;
        ifc.a = '0; ifc.ce_n = '1; ifc.ld_en = 0; ifc.ld_we = 0; ifc.ld_byte = 0;
        step(2);
        chk("rst_a_out", 32'(ifa.out), 0);
        chk("rst_a_valid", 32'(ifa.valid), 0);
        chk("rst_a_busy", 32'(ifa.ld_busy), 0);
        chk("rst_a_count", 32'(ifa.ld_count), 0);
        chk("rst_a_ovf", 32'(ifa.ld_ovf), 0);
        chk("rst_b_valid", 32'(ifb.valid), 0);
        chk("rst_c_count", 32'(ifc.ld_count), 0);
        reset_n = 1'b1;
        step();

        ifa.ld_en = 1'b1;
        sa(8'h00); sa(8'h01); sa(8'h75); sa(8'h78);
        chk("load_count", 32'(ifa.ld_count), 2);
        chk("load_busy", 32'(ifa.ld_busy), 0);
        rda(0, 4'b1110);
        chk("load_rd0", 32'(ifa.out), 32'h0001);
        chk("load_rd0_valid", 32'(ifa.valid), 1);
        rda(1, 4'b1110);
        chk("load_rd1", 32'(ifa.out), 32'h7578);

        ifa.ld_en = 1'b1;
        for (int i = 0; i <= 16'h4005; i++) begin
            w = wa(i);
            sa(w[15:8]); sa(w[7:0]);
        end
        ifa.ld_we = 1'b0;
        chk("stream_count", 32'(ifa.ld_count), 32'h4006);
        rda(5, 4'b1001);
        chk("prio_bank1", 32'(ifa.out), 32'(wa(16'h2005)));
        rda(5, 4'b1011);
        chk("prio_bank2", 32'(ifa.out), 32'(wa(16'h4005)));
        rda(5, 4'b0000);
        chk("prio_bank0", 32'(ifa.out), 32'(wa(5)));
        rda(7, 4'b1111);
        chk("idle_out", 32'(ifa.out), 0);
        chk("idle_valid", 32'(ifa.valid), 0);

        ifa.ld_en = 1'b1;
        sa(8'hAB); sa(8'hCD); sa(8'hEE);
        chk("mid_busy", 32'(ifa.ld_busy), 1);
        chk("mid_count", 32'(ifa.ld_count), 1);
        reset_n = 1'b0; ifa.ld_en = 1'b0; ifa.ld_we = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(ifa.ld_busy), 0);
        chk("mid_rst_count", 32'(ifa.ld_count), 0);
        chk("mid_rst_valid", 32'(ifa.valid), 0);
        chk("mid_rst_out", 32'(ifa.out), 0);
        step();
        reset_n = 1'b1;
        step();
        rda(1, 4'b1110);
        chk("partial_not_written", 32'(ifa.out), 32'(wa(1)));
        rda(0, 4'b1110);
        chk("whole_word_kept", 32'(ifa.out), 32'hABCD);
        ifa.ld_en = 1'b1;
        sa(8'h12); sa(8'h34);
        chk("restart_count", 32'(ifa.ld_count), 1);
        rda(0, 4'b1110);
        chk("restart_rd", 32'(ifa.out), 32'h1234);

        ifa.ld_en = 1'b1;
        sa(8'h99);
        chk("abort_busy1", 32'(ifa.ld_busy), 1);
        ifa.ld_en = 1'b0; ifa.ld_we = 1'b0;
        step();
        chk("abort_busy0", 32'(ifa.ld_busy), 0);
        chk("abort_count", 32'(ifa.ld_count), 0);
        rda(0, 4'b1110);
        chk("abort_nowrite", 32'(ifa.out), 32'h1234);
        ifa.ld_en = 1'b1; ifa.ld_we = 1'b0; ifa.a = 0; ifa.ce_n = 4'b1110;
        step(2);
        chk("rd_in_load_valid", 32'(ifa.valid), 0);
        chk("rd_in_load_out", 32'(ifa.out), 0);
        ifa.ld_en = 1'b0;

        ifb.ld_en = 1'b1;
        for (int n = 0; n < 13; n++) begin
            w = 16'($urandom);
            mb[n % 12] = w;
            sb(w[15:8]); sb(w[7:0]);
            chk("wrap_count", 32'(ifb.ld_count), 32'((n + 1) % 12));
            chk("wrap_ovf", 32'(ifb.ld_ovf), 32'(n + 1 >= 12));
        end
        ifb.ld_en = 1'b0; ifb.ld_we = 1'b0;
        for (int t = 0; t < 43; t++) begin
            if (t >= 3) begin
                e = q.pop_front();
                chk("pipe_out", 32'(ifb.out), 32'(e[15:0]));
                chk("pipe_valid", 32'(ifb.valid), 32'(e[16]));
            end
            if (t < 40) begin
                if (t < 3) begin
                    ad = t;
                    ce = ~(3'b001 << t);
                end else begin
                    ad = int'($urandom_range(0, 3));
                    ce = 3'($urandom_range(0, 7));
                end
                ifb.a = 2'(ad); ifb.ce_n = ce;
                q.push_back(ref_b(ad, ce));
            end
            step();
        end
        ifb.ld_en = 1'b1;
        step();
        chk("reraise_ovf", 32'(ifb.ld_ovf), 0);
        chk("reraise_count", 32'(ifb.ld_count), 0);
        ifb.ld_en = 1'b0;

        ifc.ld_en = 1'b1;
        sc(8'h11); sc(8'h22);
        chk("c_count", 32'(ifc.ld_count), 2);
        ifc.ld_en = 1'b0; ifc.ld_we = 1'b0; ifc.a = 0; ifc.ce_n = 2'b10;
        step();
        ifc.ld_en = 1'b1; ifc.ld_we = 1'b1; ifc.ld_byte = 8'h77;
        step();
        ifc.ld_en = 1'b0; ifc.ld_we = 1'b0;
        chk("collide_old", 32'(ifc.out), 32'h11);
        chk("collide_valid", 32'(ifc.valid), 1);
        chk("collide_count", 32'(ifc.ld_count), 1);
        step(2);
        chk("collide_new", 32'(ifc.out), 32'h77);
        ifc.a = 1; ifc.ce_n = 2'b00;
        step(2);
        chk("c_rd1", 32'(ifc.out), 32'h22);
        ifc.ce_n = 2'b11;
        step(2);
        chk("c_idle_valid", 32'(ifc.valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
